// File: rtl/spike_contrib_sweeper.sv
// Per-spike weight sweeper: for one captured {spike, src} event, reads W[t][src] for every
// active target t and streams spike*weight contributions through a small output buffer.
module spike_contrib_sweeper #(
    parameter int TEN_DATA_WIDTH  = 2,
    parameter int NEURON_ID_WIDTH = 9,
    parameter int W_WIDTH         = 8,
    parameter int SKID_DEPTH      = 4
) (
    input  logic                                      clk,
    input  logic                                      reset_l,
    input  logic                                      ev_valid,
    input  logic [TEN_DATA_WIDTH+NEURON_ID_WIDTH-1:0] ev_data,
    input  logic [3:0]                                bits_in_active_neuron,
    output logic                                      w_rd_en,
    output logic [2*NEURON_ID_WIDTH-1:0]              w_rd_addr,
    input  logic [W_WIDTH-1:0]                        w_rd_data,
    output logic                                      contrib_valid,
    input  logic                                      contrib_ready,
    output logic [NEURON_ID_WIDTH-1:0]                contrib_id,
    output logic [W_WIDTH+TEN_DATA_WIDTH-1:0]         contrib_val,
    output logic                                      busy,
    output logic                                      sweep_done,
    output logic                                      ev_overflow
);
    // state  | meaning
    // IDLE   | waiting for an event; the only state that accepts one
    // SWEEP  | issuing weight reads in ascending target order
    // DRAIN  | all reads issued; waiting for pipeline and buffer to empty
    // DONE   | one cycle, sweep_done high

    localparam int SPK = TEN_DATA_WIDTH;
    localparam int NID = NEURON_ID_WIDTH;
    localparam int CW  = W_WIDTH + TEN_DATA_WIDTH;
    localparam int PW  = $clog2(SKID_DEPTH);
    localparam int TW  = NID + 1;

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

    state_t          state;
    logic [SPK-1:0]  spike_q;
    logic [NID-1:0]  src_q;
    logic [TW-1:0]   n_q;
    logic [TW-1:0]   t_q;
    logic            inflight_q;
    logic [NID-1:0]  inflight_id;

    logic [NID-1:0]  mem_id  [SKID_DEPTH];
    logic [CW-1:0]   mem_val [SKID_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;

    logic [TW-1:0]   rd_t;
    logic [PW:0]     occ;
    logic            space;
    logic            have_t;
    logic            pop;
    logic [3:0]      bits_c;
    logic signed [CW-1:0] push_val;

    // The source target is skipped in the same cycle, so a skip costs no bandwidth.
    assign rd_t   = (t_q == {1'b0, src_q}) ? t_q + TW'(1) : t_q;
    assign occ    = count + (PW+1)'(inflight_q);
    assign space  = occ < (PW+1)'(SKID_DEPTH);
    assign have_t = rd_t < n_q;

    assign w_rd_en   = (state == S_SWEEP) && have_t && space;
    assign w_rd_addr = w_rd_en ? {rd_t[NID-1:0], src_q} : '0;

    assign contrib_valid = (count != '0);
    assign contrib_id    = mem_id[rd_ptr];
    assign contrib_val   = mem_val[rd_ptr];
    assign pop           = contrib_valid && contrib_ready;

    assign push_val = $signed({{W_WIDTH{spike_q[SPK-1]}}, spike_q})
                    * $signed({{SPK{w_rd_data[W_WIDTH-1]}}, w_rd_data});

    always_comb begin
        bits_c = bits_in_active_neuron;
        if (bits_in_active_neuron == 4'd0)
            bits_c = 4'd1;
        else if (bits_in_active_neuron > 4'(NID))
            bits_c = 4'(NID);
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            inflight_q  <= 1'b0;
            inflight_id <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_id[i]  <= '0;
                mem_val[i] <= '0;
            end
        end else begin
            inflight_q  <= w_rd_en;
            inflight_id <= rd_t[NID-1:0];
            if (inflight_q) begin
                mem_id[wr_ptr]  <= inflight_id;
                mem_val[wr_ptr] <= push_val;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(inflight_q) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state       <= S_IDLE;
            spike_q     <= '0;
            src_q       <= '0;
            n_q         <= '0;
            t_q         <= '0;
            busy        <= 1'b0;
            sweep_done  <= 1'b0;
            ev_overflow <= 1'b0;
        end else begin
            if (ev_valid && state != S_IDLE)
                ev_overflow <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (ev_valid) begin
                        spike_q <= ev_data[NID+SPK-1:NID];
                        src_q   <= ev_data[NID-1:0];
                        n_q     <= TW'(1) << bits_c;
                        t_q     <= '0;
                        busy    <= 1'b1;
                        if (ev_data[NID+SPK-1:NID] == '0) begin
                            state      <= S_DONE;
                            sweep_done <= 1'b1;
                        end else begin
                            state <= S_SWEEP;
                        end
                    end
                end
                S_SWEEP: begin
                    if (w_rd_en)
                        t_q <= rd_t + TW'(1);
                    if ((w_rd_en && rd_t == n_q - TW'(1)) || !have_t)
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    // Leave as soon as the final pop is happening this cycle.
                    if (!inflight_q && (count == '0 || (count == (PW+1)'(1) && pop))) begin
                        state      <= S_DONE;
                        sweep_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    state      <= S_IDLE;
                    sweep_done <= 1'b0;
                    busy       <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spike_contrib_sweeper.sv
// Bench for spike_contrib_sweeper: behavioural SRAM, expected-contribution scoreboard,
// a vector table of sweeps, and hand-written overflow / done-cycle / reset sequences.
module tb_spike_contrib_sweeper;
    logic        clk = 1'b0;
    logic        reset_l = 1'b0;
    logic        ev_valid = 1'b0;
    logic [10:0] ev_data = '0;
    logic [3:0]  bits = '0;
    logic        w_rd_en;
    logic [17:0] w_rd_addr;
    logic [7:0]  w_rd_data = '0;
    logic        contrib_valid;
    logic        contrib_ready = 1'b0;
    logic [8:0]  contrib_id;
    logic [9:0]  contrib_val;
    logic        busy, sweep_done, ev_overflow;

    spike_contrib_sweeper #(.TEN_DATA_WIDTH(2), .NEURON_ID_WIDTH(9), .W_WIDTH(8), .SKID_DEPTH(4)) dut (
        .clk(clk), .reset_l(reset_l), .ev_valid(ev_valid), .ev_data(ev_data),
        .bits_in_active_neuron(bits), .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
        .w_rd_data(w_rd_data), .contrib_valid(contrib_valid), .contrib_ready(contrib_ready),
        .contrib_id(contrib_id), .contrib_val(contrib_val), .busy(busy),
        .sweep_done(sweep_done), .ev_overflow(ev_overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct { int id; int val; } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [1:0] spike;
        int src;
        int bits;
        int wmode;
        int rmode;
        int exp_n;
        int exp_first;
        int exp_done;
    } vec_t;

    int w_mode = 0;
    int rmode = 0;
    logic [1:0] cur_spike = '0;
    int cur_src = 0, cur_n = 0, last_tgt = -1, first_rd = -1;
    int rx_cnt = 0, first_cyc = -1, ev_cyc = 0;
    bit held_v = 0;
    int held_id = 0, held_val = 0;

    function automatic logic [7:0] wfun(input int t, input int s);
        if (w_mode == 1) return 8'h80;
        return 8'(t * 37 + s * 11 + 5);
    endfunction

    function automatic int eprod(input logic [1:0] sp, input logic [7:0] w);
        int a, b, p;
        a = $signed(sp);
        b = $signed(w);
        p = a * b;
        return int'(p[9:0]);
    endfunction

    // Synchronous-read SRAM; garbage on idle cycles exposes any mis-timed capture.
    always @(posedge clk)
        w_rd_data <= w_rd_en ? wfun(int'(w_rd_addr[17:9]), int'(w_rd_addr[8:0])) : 8'($urandom);

    initial begin
        forever begin
            @(posedge clk); #1;
            case (rmode)
                1: contrib_ready = cyc[0];
                2: contrib_ready = 1'($urandom_range(0, 1));
                default: contrib_ready = 1'b1;
            endcase
        end
    end

    always @(negedge clk) begin
        int tgt;
        exp_t e;
        if (reset_l) begin
            if (w_rd_en) begin
                tgt = int'(w_rd_addr[17:9]);
                if (first_rd < 0) first_rd = tgt;
                chk("rd_zero_spike", int'(cur_spike == 2'b00), 0);
                chk("rd_src_field", int'(w_rd_addr[8:0]), cur_src);
                chk("rd_skip_src", int'(tgt == cur_src), 0);
                chk("rd_ascending", int'(tgt > last_tgt), 1);
                chk("rd_in_range", int'(tgt < cur_n), 1);
                last_tgt = tgt;
            end
            if (busy)
                chk("skid_occupancy", int'(dut.count > 4), 0);
            if (contrib_valid && first_cyc < 0) first_cyc = cyc - ev_cyc;
            if (held_v) begin
                chk("stall_valid", int'(contrib_valid), 1);
                chk("stall_id", int'(contrib_id), held_id);
                chk("stall_val", int'(contrib_val), held_val);
            end
            held_v   = contrib_valid && !contrib_ready;
            held_id  = int'(contrib_id);
            held_val = int'(contrib_val);
            if (contrib_valid && contrib_ready) begin
                if (sb.size() == 0) begin
                    chk("contrib_extra_id", int'(contrib_id), -1);
                end else begin
                    e = sb.pop_front();
                    chk("contrib_id", int'(contrib_id), e.id);
                    chk("contrib_val", int'(contrib_val), e.val);
                    rx_cnt++;
                end
            end
        end
    end

    task automatic send_ev(input logic [1:0] sp, input int src, input int b);
        int bb;
        exp_t e;
        @(posedge clk); #1;
        ev_valid  = 1'b1;
        ev_data   = {sp, 9'(src)};
        bits      = 4'(b);
        bb        = (b == 0) ? 1 : ((b > 9) ? 9 : b);
        cur_spike = sp;
        cur_src   = src;
        cur_n     = 1 << bb;
        last_tgt  = -1;
        first_rd  = -1;
        first_cyc = -1;
        rx_cnt    = 0;
        ev_cyc    = cyc;
        if (sp != 2'b00) begin
            for (int t = 0; t < cur_n; t++) begin
                if (t != src) begin
                    e.id  = t;
                    e.val = eprod(sp, wfun(t, src));
                    sb.push_back(e);
                end
            end
        end
        @(posedge clk); #1;
        ev_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm, output int lat);
        lat = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i == 0) chk({nm, "_busy_after_ev"}, int'(busy), 1);
            if (sweep_done) begin
                lat = cyc - ev_cyc;
                break;
            end
        end
        if (lat < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no sweep_done required within 3000 cycles", nm);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_l = 1'b0;
        held_v  = 0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 reset_l = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running required finish");
        $fatal(1, "watchdog");
    end

    vec_t vecs[8];
    int lat;
    string nm;

    initial begin
        vecs[0] = '{2'b01,   5,  3, 0, 0,   7,  3,  10};
        vecs[1] = '{2'b10,   0,  2, 1, 0,   3,  3,   6};
        vecs[2] = '{2'b00,   3,  4, 0, 0,   0, -1,   1};
        vecs[3] = '{2'b11,  20,  0, 0, 0,   2,  3,   5};
        vecs[4] = '{2'b01,   1,  1, 0, 0,   1,  3,   4};
        vecs[5] = '{2'b10, 511, 15, 0, 0, 511,  3, 514};
        vecs[6] = '{2'b01, 100,  9, 0, 1, 511,  3,  -1};
        vecs[7] = '{2'b11,   7,  5, 0, 2,  31,  3,  -1};

        reset_l = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(sweep_done), 0);
        chk("rst_ovf", int'(ev_overflow), 0);
        chk("rst_valid", int'(contrib_valid), 0);
        chk("rst_rd_en", int'(w_rd_en), 0);
        @(posedge clk); #1 reset_l = 1'b1;

        foreach (vecs[k]) begin
            nm     = $sformatf("vec%0d", k);
            w_mode = vecs[k].wmode;
            rmode  = vecs[k].rmode;
            send_ev(vecs[k].spike, vecs[k].src, vecs[k].bits);
            wait_done(nm, lat);
            if (vecs[k].exp_done >= 0) chk({nm, "_done_cycle"}, lat, vecs[k].exp_done);
            if (vecs[k].exp_first >= 0) chk({nm, "_first_valid"}, first_cyc, vecs[k].exp_first);
            chk({nm, "_count"}, rx_cnt, vecs[k].exp_n);
            chk({nm, "_sb_left"}, sb.size(), 0);
            chk({nm, "_valid_at_done"}, int'(contrib_valid), 0);
            @(negedge clk);
            chk({nm, "_busy_after"}, int'(busy), 0);
            chk({nm, "_done_pulse"}, int'(sweep_done), 0);
        end
        chk("ovf_clean", int'(ev_overflow), 0);

        // Event arriving in the DONE cycle of a zero-spike sweep is dropped.
        w_mode = 0;
        rmode  = 0;
        @(posedge clk); #1;
        ev_valid = 1'b1; ev_data = {2'b00, 9'd3}; bits = 4'd3;
        cur_spike = 2'b00; cur_src = 3; cur_n = 8; last_tgt = -1; ev_cyc = cyc;
        @(posedge clk); #1;
        ev_data = {2'b01, 9'd2};
        @(negedge clk);
        chk("done_drop_pulse", int'(sweep_done), 1);
        @(posedge clk); #1 ev_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("done_drop_idle", int'(busy), 0);
        end
        chk("done_drop_ovf", int'(ev_overflow), 1);

        // Second event during a sweep sets the sticky flag and is otherwise ignored.
        do_reset();
        @(negedge clk);
        chk("ovf_after_reset", int'(ev_overflow), 0);
        send_ev(2'b01, 2, 3);
        repeat (3) begin @(posedge clk); #1; end
        ev_valid = 1'b1; ev_data = {2'b11, 9'd6}; bits = 4'd9;
        @(posedge clk); #1 ev_valid = 1'b0;
        @(negedge clk);
        chk("ovf_set", int'(ev_overflow), 1);
        wait_done("ovf_sweep", lat);
        chk("ovf_sweep_done_cycle", lat, 10);
        chk("ovf_sweep_count", rx_cnt, 7);
        chk("ovf_sweep_sb_left", sb.size(), 0);
        repeat (4) @(negedge clk);
        chk("ovf_sticky", int'(ev_overflow), 1);
        chk("ovf_no_second_sweep", int'(busy), 0);

        // Reset in the middle of a long sweep.
        do_reset();
        send_ev(2'b01, 300, 9);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (w_rd_en && w_rd_addr[17:9] == 9'd100) break;
        end
        chk("mid_reached_100", int'(w_rd_addr[17:9]), 100);
        #1 reset_l = 1'b0;
        #1;
        chk("mid_rst_rd_en", int'(w_rd_en), 0);
        chk("mid_rst_addr", int'(w_rd_addr), 0);
        chk("mid_rst_valid", int'(contrib_valid), 0);
        chk("mid_rst_id", int'(contrib_id), 0);
        chk("mid_rst_val", int'(contrib_val), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(sweep_done), 0);
        held_v = 0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 reset_l = 1'b1;
        send_ev(2'b11, 5, 3);
        wait_done("post_rst", lat);
        chk("post_rst_first_target", first_rd, 0);
        chk("post_rst_done_cycle", lat, 10);
        chk("post_rst_count", rx_cnt, 7);
        chk("post_rst_sb_left", sb.size(), 0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
